// File: rtl/decode_stage_pkg.sv
// Shared RV32I instruction package: opcode/funct constants, decoded-class enum,
// output-register state enum and opcode/funct legality helpers.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
    CLS_LOAD, CLS_STORE, CLS_OP_IMM, CLS_OP, CLS_ILLEGAL
  } instr_class_e;

  typedef enum logic {ST_EMPTY, ST_FULL} out_state_e;

  function automatic instr_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_OP_IMM: return CLS_OP_IMM;
      OPC_OP:     return CLS_OP;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic funct_legal(input instr_class_e cls, input logic [2:0] f3,
                                       input logic [6:0] f7);
    case (cls)
      CLS_LUI, CLS_AUIPC, CLS_JAL: return 1'b1;
      CLS_JALR:   return f3 == F3_JALR;
      CLS_BRANCH: return f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
      CLS_LOAD:   return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      CLS_STORE:  return f3 inside {F3_SB, F3_SH, F3_SW};
      CLS_OP_IMM: begin
        if (f3 == F3_SLL) return f7 == F7_BASE;
        if (f3 == F3_SR)  return f7 inside {F7_BASE, F7_ALT};
        return 1'b1;
      end
      CLS_OP:     return (f7 == F7_BASE) || (f7 == F7_ALT && f3 inside {F3_ADD, F3_SR});
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate extraction (I/S/B/U/J), sign-extended to XLEN.
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_s,
  output logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] imm_j
);

  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with load-use stall and registered output slot.
// Optional EX->decode operand bypass enabled by defining DECODE_BYPASS_EN.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [RW-1:0]   rf_raddr1,
  output logic [RW-1:0]   rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            ex_wen,
  input  logic [RW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ex_is_load,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [RW-1:0]   out_rd,
  output logic            out_wen,
  output logic            out_load,
  output logic            out_store,
  output logic [XLEN-1:0] out_mem_addr,
  output logic [XLEN-1:0] out_store_data,
  output logic            out_illegal
);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  instr_class_e    cls;
  logic            legal, use_rs1, use_rs2, hit1, hit2, stall, accept;
  logic [RW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val;
  out_state_e      state;

  assign rs1       = RW'(in_instr[19:15]);
  assign rs2       = RW'(in_instr[24:20]);
  assign rd        = RW'(in_instr[11:7]);
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  assign cls     = classify(in_instr[6:0]);
  assign legal   = funct_legal(cls, in_instr[14:12], in_instr[31:25]);
  assign use_rs1 = cls inside {CLS_JALR, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_OP_IMM, CLS_OP};
  assign use_rs2 = cls inside {CLS_BRANCH, CLS_STORE, CLS_OP};

  // x0 never matches, so it neither stalls nor takes a bypass.
  assign hit1 = ex_wen && (ex_rd != '0) && use_rs1 && (ex_rd == rs1);
  assign hit2 = ex_wen && (ex_rd != '0) && use_rs2 && (ex_rd == rs2);

`ifdef DECODE_BYPASS_EN
  logic unused_bits;
  assign unused_bits = ^imm_b;
  assign stall   = (hit1 || hit2) && ex_is_load;
  assign rs1_val = (hit1 && !ex_is_load) ? ex_data : rf_rdata1;
  assign rs2_val = (hit2 && !ex_is_load) ? ex_data : rf_rdata2;
`else
  logic unused_bits;
  assign unused_bits = ^{imm_b, ex_data};
  assign stall   = hit1 || hit2;
  assign rs1_val = rf_rdata1;
  assign rs2_val = rf_rdata2;
`endif

  assign in_ready  = ((state == ST_EMPTY) || out_ready) && !stall && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_FULL);

  logic [XLEN-1:0] d_op1, d_op2, d_mem, d_sd;
  logic            d_wen, d_load, d_store, d_illegal;

  always_comb begin
    d_op1     = '0;
    d_op2     = '0;
    d_mem     = '0;
    d_sd      = '0;
    d_wen     = 1'b0;
    d_load    = 1'b0;
    d_store   = 1'b0;
    d_illegal = (cls == CLS_ILLEGAL) || !legal;
    case (cls)
      CLS_LUI:    begin d_op2 = imm_u; d_wen = 1'b1; end
      CLS_AUIPC:  begin d_op1 = in_pc; d_op2 = imm_u; d_wen = 1'b1; end
      CLS_JAL:    begin d_op1 = in_pc; d_op2 = imm_j; d_wen = 1'b1; end
      CLS_JALR:   begin d_op1 = rs1_val; d_op2 = imm_i; d_wen = 1'b1; end
      CLS_BRANCH: begin d_op1 = rs1_val; d_op2 = rs2_val; end
      CLS_LOAD:   begin d_mem = rs1_val + imm_i; d_load = 1'b1; d_wen = 1'b1; end
      CLS_STORE:  begin d_mem = rs1_val + imm_s; d_sd = rs2_val; d_store = 1'b1; end
      CLS_OP_IMM: begin
        d_op1 = rs1_val;
        d_op2 = (in_instr[14:12] inside {F3_SLL, F3_SR}) ? XLEN'(in_instr[24:20]) : imm_i;
        d_wen = 1'b1;
      end
      CLS_OP:     begin d_op1 = rs1_val; d_op2 = rs2_val; d_wen = 1'b1; end
      default:    ;
    endcase
    if (d_illegal) begin
      d_wen   = 1'b0;
      d_load  = 1'b0;
      d_store = 1'b0;
    end
    if (rd == '0) d_wen = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_EMPTY;
      out_pc         <= '0;
      out_instr      <= '0;
      out_op1        <= '0;
      out_op2        <= '0;
      out_rd         <= '0;
      out_wen        <= 1'b0;
      out_load       <= 1'b0;
      out_store      <= 1'b0;
      out_mem_addr   <= '0;
      out_store_data <= '0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else if (accept) begin
      state          <= ST_FULL;
      out_pc         <= in_pc;
      out_instr      <= in_instr;
      out_op1        <= d_op1;
      out_op2        <= d_op2;
      out_rd         <= rd;
      out_wen        <= d_wen;
      out_load       <= d_load;
      out_store      <= d_store;
      out_mem_addr   <= d_mem;
      out_store_data <= d_sd;
      out_illegal    <= d_illegal;
    end else if (state == ST_FULL && out_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// against a behavioural decode model. Honours DECODE_BYPASS_EN like the design.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc, instr, op1, op2, mem, sd;
    logic [4:0]  rd;
    logic        wen, load, store, illegal;
  } out_t;

  logic        clk = 1'b0, rst_n, in_valid, in_ready, ex_wen, ex_is_load, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rf_rdata1, rf_rdata2, ex_data;
  logic [31:0] out_pc, out_instr, out_op1, out_op2, out_mem_addr, out_store_data;
  logic [4:0]  rf_raddr1, rf_raddr2, ex_rd, out_rd;
  logic        out_wen, out_load, out_store, out_illegal;
  logic [31:0] regfile [32];
  out_t        obs;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = regfile[rf_raddr1];
  assign rf_rdata2 = regfile[rf_raddr2];
  assign obs = {out_pc, out_instr, out_op1, out_op2, out_mem_addr, out_store_data,
                out_rd, out_wen, out_load, out_store, out_illegal};

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .ex_wen(ex_wen), .ex_rd(ex_rd),
    .ex_data(ex_data), .ex_is_load(ex_is_load), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_op1(out_op1),
    .out_op2(out_op2), .out_rd(out_rd), .out_wen(out_wen), .out_load(out_load),
    .out_store(out_store), .out_mem_addr(out_mem_addr), .out_store_data(out_store_data),
    .out_illegal(out_illegal)
  );

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic void uses(logic [31:0] ins, output bit u1, output bit u2);
    u1 = ins[6:0] inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    u2 = ins[6:0] inside {7'h63, 7'h23, 7'h33};
  endfunction

  // Reference decode from the ISA field rules; a/b are the rs1/rs2 values after any bypass.
  function automatic out_t model(logic [31:0] ins, logic [31:0] pc, logic [31:0] a, logic [31:0] b);
    out_t e;
    int ii, si, ui, ji;
    bit legal, wr, ld, st;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0; e.pc = pc; e.instr = ins; e.rd = ins[11:7];
    f3 = ins[14:12]; f7 = ins[31:25];
    ii = $signed(ins[31:20]);
    si = $signed({ins[31:25], ins[11:7]});
    ui = {ins[31:12], 12'h000};
    ji = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
    wr = 0; ld = 0; st = 0;
    case (ins[6:0])
      7'h37: begin legal = 1; e.op2 = ui; wr = 1; end
      7'h17: begin legal = 1; e.op1 = pc; e.op2 = ui; wr = 1; end
      7'h6F: begin legal = 1; e.op1 = pc; e.op2 = ji; wr = 1; end
      7'h67: begin legal = (f3 == 0); e.op1 = a; e.op2 = ii; wr = 1; end
      7'h63: begin legal = (f3 != 2 && f3 != 3); e.op1 = a; e.op2 = b; end
      7'h03: begin legal = (f3 != 3 && f3 < 6); e.mem = a + ii; ld = 1; wr = 1; end
      7'h23: begin legal = (f3 < 3); e.mem = a + si; e.sd = b; st = 1; end
      7'h13: begin
        legal = (f3 == 1) ? (f7 == 0) : ((f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1);
        e.op1 = a;
        e.op2 = (f3 == 1 || f3 == 5) ? {27'd0, ins[24:20]} : ii;
        wr = 1;
      end
      7'h33: begin legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); e.op1 = a; e.op2 = b; wr = 1; end
      default: legal = 0;
    endcase
    e.wen = wr && legal && (ins[11:7] != 0);
    e.load = ld && legal;
    e.store = st && legal;
    e.illegal = !legal;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc, f7;
    case ($urandom_range(0, 10))
      0: opc = 7'h37; 1: opc = 7'h17; 2: opc = 7'h6F; 3: opc = 7'h67;
      4: opc = 7'h63; 5: opc = 7'h03; 6: opc = 7'h23; 7: opc = 7'h13;
      8: opc = 7'h33; 9: opc = 7'h7F; default: opc = 7'h0B;
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00; 1: f7 = 7'h20; default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 7)), opc};
  endfunction

  task automatic idle();
    in_valid = 0; in_instr = 0; in_pc = 0; ex_wen = 0; ex_rd = 0; ex_data = 0;
    ex_is_load = 0; flush = 0; out_ready = 1;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; cyc(); cyc(); rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset(); rst_n = 0; #1;
    n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", obs); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    cyc();
    rst_n = 1; in_valid = 1; in_pc = 32'h40; in_instr = enc_i(12'd7, 5'd0, 3'd0, 5'd9, 7'h13);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    cyc();
    n_checks++; if (out_valid !== 1'b1 || out_op2 !== 32'd7) begin
      n_fail++; $display("FAIL first_accept got valid=%b op2=%h exp valid=1 op2=7", out_valid, out_op2); end
    idle(); cyc();
  endtask

  task automatic test_addi();
    regfile[1] = 32'd10;
    in_valid = 1; in_pc = 32'h100; in_instr = enc_i(12'hFFF, 5'd1, 3'd0, 5'd5, 7'h13);
    cyc();
    n_checks++; if ({out_valid, out_op1, out_op2, out_rd, out_wen} !== {1'b1, 32'd10, 32'hFFFF_FFFF, 5'd5, 1'b1}) begin
      n_fail++; $display("FAIL addi got v=%b op1=%h op2=%h rd=%0d wen=%b exp v=1 op1=a op2=ffffffff rd=5 wen=1",
                         out_valid, out_op1, out_op2, out_rd, out_wen); end
    idle(); cyc();
  endtask

  task automatic test_load_store();
    regfile[2] = 32'h100; regfile[3] = 32'hDEAD_BEEF;
    in_valid = 1; in_pc = 32'h104; in_instr = enc_i(12'd8, 5'd2, 3'd2, 5'd3, 7'h03);
    cyc();
    n_checks++; if ({out_mem_addr, out_load, out_store, out_wen} !== {32'h108, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL lw got addr=%h ld=%b st=%b wen=%b exp addr=108 ld=1 st=0 wen=1",
                         out_mem_addr, out_load, out_store, out_wen); end
    in_pc = 32'h108; in_instr = enc_s(-12'sd4, 5'd3, 5'd2, 3'd2, 7'h23);
    cyc();
    n_checks++; if ({out_mem_addr, out_store_data, out_store, out_load, out_wen} !== {32'hFC, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sw got addr=%h sd=%h st=%b ld=%b wen=%b exp addr=fc sd=deadbeef st=1 ld=0 wen=0",
                         out_mem_addr, out_store_data, out_store, out_load, out_wen); end
    idle(); cyc();
  endtask

  task automatic test_load_stall();
    regfile[1] = 32'h11; regfile[2] = 32'h22;
    in_valid = 1; in_pc = 32'h200; in_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd6, 7'h13);
    cyc();
    ex_is_load = 1; ex_wen = 1; ex_rd = 2; in_pc = 32'h204;
    in_instr = enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd4, 7'h33);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b exp 0", in_ready); end
    cyc();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_bubble got %b exp 0", out_valid); end
    ex_is_load = 0; ex_wen = 0; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b exp 1", in_ready); end
    cyc();
    n_checks++; if ({out_valid, out_pc, out_op1, out_op2} !== {1'b1, 32'h204, 32'h22, 32'h11}) begin
      n_fail++; $display("FAIL stall_accept got v=%b pc=%h op1=%h op2=%h exp v=1 pc=204 op1=22 op2=11",
                         out_valid, out_pc, out_op1, out_op2); end
    idle(); cyc();
  endtask

  task automatic test_backpressure();
    out_t snap;
    in_valid = 1; in_pc = 32'h300; in_instr = enc_i(12'd5, 5'd1, 3'd0, 5'd7, 7'h13);
    cyc();
    snap = obs;
    out_ready = 0; in_pc = 32'h304; in_instr = enc_i(12'd9, 5'd1, 3'd0, 5'd8, 7'h13);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", k, in_ready); end
      cyc();
      n_checks++; if ({out_valid, obs} !== {1'b1, snap}) begin
        n_fail++; $display("FAIL bp_hold[%0d] got %b %h exp 1 %h", k, out_valid, obs, snap); end
    end
    out_ready = 1; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b exp 1", in_ready); end
    cyc();
    n_checks++; if ({out_valid, out_pc, out_rd} !== {1'b1, 32'h304, 5'd8}) begin
      n_fail++; $display("FAIL bp_transfer got v=%b pc=%h rd=%0d exp v=1 pc=304 rd=8", out_valid, out_pc, out_rd); end
    idle(); cyc();
  endtask

  task automatic test_bypass();
    regfile[1] = 32'h55;
    in_valid = 1; in_pc = 32'h400; in_instr = enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd4, 7'h33);
    ex_wen = 1; ex_rd = 1; ex_data = 32'hAA; #1;
`ifdef DECODE_BYPASS_EN
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL byp_ready got %b exp 1", in_ready); end
    cyc();
    n_checks++; if ({out_valid, out_op1} !== {1'b1, 32'hAA}) begin
      n_fail++; $display("FAIL byp_op1 got v=%b op1=%h exp v=1 op1=aa", out_valid, out_op1); end
`else
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL nobyp_ready got %b exp 0", in_ready); end
    cyc();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nobyp_bubble got %b exp 0", out_valid); end
    ex_wen = 0; cyc();
    n_checks++; if ({out_valid, out_op1} !== {1'b1, 32'h55}) begin
      n_fail++; $display("FAIL nobyp_op1 got v=%b op1=%h exp v=1 op1=55", out_valid, out_op1); end
`endif
    ex_wen = 1; ex_is_load = 1; ex_rd = 0; ex_data = 32'h77; in_pc = 32'h404;
    in_instr = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd4, 7'h33); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_nostall got %b exp 1", in_ready); end
    cyc();
    n_checks++; if ({out_valid, out_op1, out_op2} !== {1'b1, 64'd0}) begin
      n_fail++; $display("FAIL x0_nobypass got v=%b op1=%h op2=%h exp v=1 op1=0 op2=0", out_valid, out_op1, out_op2); end
    idle(); cyc();
  endtask

  task automatic test_illegal_flush();
    in_valid = 1; in_pc = 32'h500; in_instr = 32'h0000_02FF; out_ready = 0;
    cyc();
    n_checks++; if ({out_valid, out_illegal, out_wen, out_load, out_store} !== 5'b11000) begin
      n_fail++; $display("FAIL illegal got v=%b ill=%b wen=%b ld=%b st=%b exp 1 1 0 0 0",
                         out_valid, out_illegal, out_wen, out_load, out_store); end
    flush = 1; in_pc = 32'h504; in_instr = enc_i(12'd1, 5'd1, 3'd0, 5'd2, 7'h13); #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b exp 0", in_ready); end
    cyc();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    flush = 0; in_pc = 32'h508; cyc();
    in_pc = 32'h50C; #2; rst_n = 0; #1;
    n_checks++; if ({out_valid, obs} !== '0) begin n_fail++; $display("FAIL rst_mid got %b %h exp all 0", out_valid, obs); end
    #1; rst_n = 1; out_ready = 1; #1;
    cyc();
    n_checks++; if ({out_valid, out_pc} !== {1'b1, 32'h50C}) begin
      n_fail++; $display("FAIL rst_reaccept got v=%b pc=%h exp v=1 pc=50c", out_valid, out_pc); end
    idle(); cyc();
  endtask

  task automatic test_random();
    out_t held, nxt;
    bit hv, u1, u2, h1, h2, stall, exp_rdy;
    logic [31:0] a, b;
    logic [4:0] r1, r2;
    do_reset(); hv = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom); in_instr = rand_instr(); in_pc = $urandom;
      ex_wen = 1'($urandom); ex_rd = 5'($urandom_range(0, 3)); ex_data = $urandom;
      ex_is_load = ($urandom_range(0, 2) == 0); out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      r1 = in_instr[19:15]; r2 = in_instr[24:20];
      uses(in_instr, u1, u2);
      a = regfile[r1]; b = regfile[r2];
      h1 = ex_wen && ex_rd != 0 && u1 && ex_rd == r1;
      h2 = ex_wen && ex_rd != 0 && u2 && ex_rd == r2;
`ifdef DECODE_BYPASS_EN
      stall = (h1 || h2) && ex_is_load;
      if (h1 && !ex_is_load) a = ex_data;
      if (h2 && !ex_is_load) b = ex_data;
`else
      stall = h1 || h2;
`endif
      exp_rdy = (!hv || out_ready) && !stall && !flush;
      nxt = model(in_instr, in_pc, a, b);
      n_checks++; if ({rf_raddr1, rf_raddr2, in_ready} !== {r1, r2, exp_rdy}) begin
        n_fail++; $display("FAIL rnd_comb[%0d] got ra1=%0d ra2=%0d rdy=%b exp %0d %0d %b",
                           c, rf_raddr1, rf_raddr2, in_ready, r1, r2, exp_rdy); end
      cyc();
      if (flush) hv = 0;
      else if (in_valid && exp_rdy) begin hv = 1; held = nxt; end
      else if (hv && out_ready) hv = 0;
      n_checks++; if (out_valid !== hv) begin
        n_fail++; $display("FAIL rnd_valid[%0d] got %b exp %b", c, out_valid, hv); end
      if (hv) begin
        n_checks++; if (obs !== held) begin
          n_fail++; $display("FAIL rnd_out[%0d] got %h exp %h", c, obs, held); end
      end
    end
    idle(); cyc();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = (i == 0) ? 32'd0 : $urandom;
    rst_n = 0; idle();
    test_reset();
    test_addi();
    test_load_store();
    test_load_stall();
    test_backpressure();
    test_bypass();
    test_illegal_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
- REQ-001 SHALL have parameter XLEN, default 32, datapath width for PC, operands, addresses and data.
- REQ-002 SHALL have parameter NREG, default 32, architectural register count; register index width RW = log2(NREG).
- REQ-003 Clock and reset: one clock; reset is asynchronous and active-low. Ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
- REQ-004 SHALL have these upstream ports: in_valid in 1; in_ready out 1; in_instr in 32; in_pc in XLEN.
- REQ-005 SHALL have these register-file ports: rf_raddr1 out RW; rf_raddr2 out RW; rf_rdata1 in XLEN; rf_rdata2 in XLEN (combinational read).
- REQ-006 SHALL have these hazard/bypass ports: ex_wen in 1; ex_rd in RW; ex_data in XLEN; ex_is_load in 1 (EX-stage load result not yet available).
- REQ-007 SHALL have flush in 1, which kills the held and the incoming instruction.
- REQ-008 SHALL have these downstream ports: out_valid out 1; out_ready in 1; out_pc XLEN; out_instr 32; out_op1 XLEN; out_op2 XLEN; out_rd RW; out_wen 1; out_load 1; out_store 1; out_mem_addr XLEN; out_store_data XLEN; out_illegal 1 (all registered outputs).

Function
- REQ-009 SHALL drive rf_raddr1 = in_instr[19:15] and rf_raddr2 = in_instr[24:20] combinationally.
- REQ-010 SHALL decode opcode classes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP, with operand selection as follows.
  - LUI: op1 = 0, op2 = U-imm.
  - AUIPC/JAL: op1 = pc, op2 = U/J-imm.
  - JALR/OP-IMM: op1 = rs1, op2 = I-imm (shifts: shamt zero-extended).
  - BRANCH/OP: op1 = rs1, op2 = rs2.
- REQ-011 SHALL compute mem_addr = rs1 + I-imm for loads and rs1 + S-imm for stores, modulo 2^XLEN; store_data = rs2.
- REQ-012 SHALL set out_wen for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, forced to 0 when rd = 0.
- REQ-013 SHALL treat any undefined opcode or funct3 as illegal: out_illegal = 1, out_wen = out_load = out_store = 0, and the instruction still passes downstream.
- REQ-014 SHALL use an output register FSM with states EMPTY and FULL.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on out_ready without accept.
  - FULL→FULL on simultaneous out_ready and accept.
- REQ-015 Accept = in_valid & in_ready; in_ready = (EMPTY | out_ready) & ~stall & ~flush.
- REQ-016 SHALL raise stall when ex_is_load & ex_wen & ex_rd ≠ 0 and ex_rd matches a source register actually used by the instruction. While stalled, in_ready = 0 and the FSM inserts a bubble (out_valid drops if drained).
- REQ-017 Latency: one cycle from accept to out_valid.
- REQ-018 Backpressure: while out_valid & ~out_ready, all out_* SHALL hold stable.
- REQ-019 Flush: the FSM goes to EMPTY next cycle and in_ready = 0 in the flush cycle; flush has priority over accept and stall.
- REQ-020 SHALL raise no stall and perform no bypass when the source register is x0.

Reset
- REQ-021 On rst_n low: FSM = EMPTY; out_valid, out_wen, out_load, out_store, out_illegal = 0; all data outputs = 0; reset effect is immediate, including mid-handshake.
- REQ-022 The first accept SHALL be possible in the first clk edge after rst_n deasserts.

Configuration
- REQ-023 Macro DECODE_BYPASS_EN.
  - Defined: a non-load ex_wen match (ex_rd ≠ 0) substitutes ex_data for the rs value with no stall.
  - Undefined: the same match raises stall per REQ-016 rules until ex_wen drops.

Structure
- REQ-024 Opcode, funct3 and funct7 constants plus a decoded-class enum SHALL reside in the shared RV32I instruction package.
- REQ-025 Immediate generation SHALL be the sub-module imm_gen (instr in, five XLEN immediates out, combinational).

Verification
- REQ-026 The bench SHALL cover these directed scenarios:
  - ADDI x5,x1,-1 with rf_rdata1=10 → next cycle out_op1=10, out_op2=0xFFFFFFFF, out_rd=5, out_wen=1.
  - LW x3,8(x2) with rdata=0x100 → out_mem_addr=0x108, out_load=1; SW x3,-4(x2) → out_mem_addr=0xFC, out_store_data=rdata2.
  - ex_is_load=1, ex_rd=2, ex_wen=1, next ADD x4,x2,x1 → in_ready=0 one cycle, bubble, then accepted.
  - out_ready=0 for 3 cycles with FULL → outputs stable, in_ready=0; release → both transfer same cycle.
  - Bypass: ex_wen=1, ex_rd=1, ex_data=0xAA, ADD x4,x1,x0 → with macro out_op1=0xAA; without macro one-cycle stall.
  - Opcode 0x7F → out_illegal=1, out_wen=0; flush while FULL → out_valid=0 next cycle; rst_n low mid-transfer → all outputs 0.
